// File: rtl/serdes_pkg.sv
// Shared types and constants for the serdes lane.
// The RX alignment FSM states and the default K28.5 comma symbol live here.
package serdes_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  // K28.5 with negative running disparity; bit0 goes on the line first.
  localparam logic [9:0] K28_5_RDN = 10'h17C;

endpackage

// File: rtl/serdes_rx_align.sv
// RX side of the lane: sliding comma window, symbol phase counter,
// HUNT/SYNC/LOCKED alignment FSM and registered symbol outputs.
module serdes_rx_align
  import serdes_pkg::*;
#(
  parameter int               SYM_W    = 10,
  parameter logic [SYM_W-1:0] COMMA    = SYM_W'(K28_5_RDN),
  parameter int               LOCK_CNT = 3,
  parameter int               LOSS_CNT = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_bit_i,
  output logic [SYM_W-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             rx_is_comma_o,
  output logic             rx_locked_o
);

  localparam int PW = (SYM_W > 1) ? $clog2(SYM_W) : 1;
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(SYM_W - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LOCK_CNT);
  localparam logic [MW-1:0] MISS_MAX = MW'(LOSS_CNT);

  logic [SYM_W-1:0] window_q;
  logic [PW-1:0]    phase_q;
  logic [CW-1:0]    cnt_q;
  logic [MW-1:0]    miss_q;
  rx_state_t        state_q;
  logic [SYM_W-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             rx_is_comma_q;
  logic             rx_locked_q;

  logic             comma_hit_s;
  logic             boundary_s;
  logic [CW-1:0]    cnt_inc_s;
  logic [MW-1:0]    miss_inc_s;

  // Comma detection, boundary decode and saturating increments.
  always_comb begin
    comma_hit_s = (window_q == COMMA) || (window_q == ~COMMA);
    boundary_s  = (phase_q == PH_LAST);
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CW'(1);
    end
    if (miss_q == MISS_MAX) begin
      miss_inc_s = miss_q;
    end else begin
      miss_inc_s = miss_q + MW'(1);
    end
  end

  // Window shift, phase tracking and alignment FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      window_q      <= '0;
      phase_q       <= '0;
      cnt_q         <= '0;
      miss_q        <= '0;
      state_q       <= HUNT;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_is_comma_q <= 1'b0;
      rx_locked_q   <= 1'b0;
    end else begin
      window_q      <= {rx_bit_i, window_q[SYM_W-1:1]};
      phase_q       <= boundary_s ? '0 : phase_q + PW'(1);
      rx_valid_q    <= 1'b0;
      rx_is_comma_q <= 1'b0;
      case (state_q)
        HUNT: begin
          rx_locked_q <= 1'b0;
          if (comma_hit_s) begin
            // Treat this cycle as the symbol boundary from now on.
            phase_q <= '0;
            cnt_q   <= CW'(1);
            miss_q  <= '0;
            if (LOCK_CNT == 1) begin
              state_q     <= LOCKED;
              rx_locked_q <= 1'b1;
            end else begin
              state_q <= SYNC;
            end
          end
        end
        SYNC: begin
          if (comma_hit_s && boundary_s) begin
            cnt_q <= cnt_inc_s;
            if (cnt_inc_s >= CNT_MAX) begin
              state_q     <= LOCKED;
              rx_locked_q <= 1'b1;
              miss_q      <= '0;
            end
          end else if (comma_hit_s) begin
            phase_q <= '0;
            cnt_q   <= CW'(1);
          end else if (boundary_s) begin
            state_q <= HUNT;
            cnt_q   <= '0;
          end
        end
        LOCKED: begin
          if (boundary_s) begin
            rx_valid_q    <= 1'b1;
            rx_data_q     <= window_q;
            rx_is_comma_q <= comma_hit_s;
            if (comma_hit_s) begin
              miss_q <= '0;
            end
          end else if (comma_hit_s) begin
            miss_q <= miss_inc_s;
            if (miss_inc_s >= MISS_MAX) begin
              state_q     <= HUNT;
              rx_locked_q <= 1'b0;
              cnt_q       <= '0;
            end
          end
        end
        default: begin
          state_q     <= HUNT;
          rx_locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_is_comma_o = rx_is_comma_q;
  assign rx_locked_o   = rx_locked_q;

endmodule

// File: rtl/serdes_lane.sv
// Single serdes lane: LSB-first serializer with comma fill, loopback mux,
// and the RX alignment block.
module serdes_lane
  import serdes_pkg::*;
#(
  parameter int               SYM_W    = 10,
  parameter logic [SYM_W-1:0] COMMA    = SYM_W'(K28_5_RDN),
  parameter int               LOCK_CNT = 3,
  parameter int               LOSS_CNT = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [SYM_W-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             ser_out_o,
  input  logic             ser_in_i,
  input  logic             loopback_i,
  output logic [SYM_W-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             rx_is_comma_o,
  output logic             rx_locked_o
);

  localparam int BW = (SYM_W > 1) ? $clog2(SYM_W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(SYM_W - 1);

  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SYM_W-1:0] shift_q, shift_d;
  logic             ser_out_q, ser_out_d;
  logic             started_q, started_d;

  logic             load_slot_s;
  logic             tx_ready_s;
  logic [SYM_W-1:0] load_sym_s;
  logic             rx_bit_s;

  // Load slot decode and next-state for the serializer. The first slot after
  // reset is never offered to the source, so the line restarts with a comma.
  always_comb begin
    load_slot_s = (bit_cnt_q == BIT_LAST);
    tx_ready_s  = load_slot_s && started_q;
    started_d   = 1'b1;
    if (tx_ready_s && tx_valid_i) begin
      load_sym_s = tx_data_i;
    end else begin
      load_sym_s = COMMA;
    end
    if (load_slot_s) begin
      bit_cnt_d = '0;
      shift_d   = {1'b0, load_sym_s[SYM_W-1:1]};
      ser_out_d = load_sym_s[0];
    end else begin
      bit_cnt_d = bit_cnt_q + BW'(1);
      shift_d   = {1'b0, shift_q[SYM_W-1:1]};
      ser_out_d = shift_q[0];
    end
    rx_bit_s = loopback_i ? ser_out_q : ser_in_i;
  end

  // Serializer state.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bit_cnt_q <= BIT_LAST;
      shift_q   <= COMMA;
      ser_out_q <= 1'b0;
      started_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ser_out_q <= ser_out_d;
      started_q <= started_d;
    end
  end

  assign tx_ready_o = tx_ready_s;
  assign ser_out_o  = ser_out_q;

  serdes_rx_align #(
    .SYM_W   (SYM_W),
    .COMMA   (COMMA),
    .LOCK_CNT(LOCK_CNT),
    .LOSS_CNT(LOSS_CNT)
  ) u_rx_align (
    .clk_i        (clk_i),
    .rst_ni       (reset_ni),
    .rx_bit_i     (rx_bit_s),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_is_comma_o(rx_is_comma_o),
    .rx_locked_o  (rx_locked_o)
  );

endmodule

// File: tb/tb_serdes_lane.sv
// Directed bench for serdes_lane: loopback lock, data transfer, phase slip,
// inverted comma lock and mid-symbol reset.
module tb_serdes_lane;

  localparam logic [9:0] C  = 10'h17C;
  localparam logic [9:0] CN = 10'h283;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ser_out;
  logic       ser_in;
  logic       loopback;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       rx_is_comma;
  logic       rx_locked;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int valid_cnt = 0;

  typedef struct {
    logic [9:0] d;
    logic       c;
    int         at;
  } rx_ev_t;

  rx_ev_t     rx_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] tbl[8] = '{10'h2AA, 10'h155, 10'h333, 10'h0CC,
                         10'h199, 10'h266, 10'h0AA, 10'h354};

  serdes_lane dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .ser_out_o    (ser_out),
    .ser_in_i     (ser_in),
    .loopback_i   (loopback),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_is_comma_o(rx_is_comma),
    .rx_locked_o  (rx_locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rx_ev_t ev;
    if (rx_valid) begin
      ev.d  = rx_data;
      ev.c  = rx_is_comma;
      ev.at = cyc;
      rx_q.push_back(ev);
      valid_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output rx_ev_t ev, output bit ok);
    ok    = 1'b0;
    ev.d  = '0;
    ev.c  = 1'b0;
    ev.at = 0;
    for (int i = 0; i < budget; i++) begin
      if (rx_q.size() > 0) begin
        ev = rx_q.pop_front();
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok && rx_q.size() > 0) begin
      ev = rx_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic send_sym(input logic [9:0] d, input string tag);
    bit got;
    got      = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tx_ready) begin
        got = 1'b1;
        step();
        break;
      end
      step();
    end
    chk(tag, got, 1'b1);
  endtask

  task automatic drive_sym(input logic [9:0] s);
    for (int k = 0; k < 10; k++) begin
      step();
      ser_in = s[k];
    end
  endtask

  initial begin
    rx_ev_t     ev, ev2;
    bit         ok;
    logic [19:0] cap;
    logic [9:0]  cap10;
    int          rdy_cnt;
    int          vc;

    reset_n  = 1'b0;
    loopback = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    ser_in   = 1'b0;

    // Reset state and comma fill after release.
    #12;
    chk("reset_outs", {tx_ready, ser_out, rx_valid, rx_is_comma, rx_locked, rx_data}, 32'd0);
    step();
    reset_n = 1'b1;
    chk("tx_ready_first_cycle", tx_ready, 1'b0);
    rdy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      cap[k] = ser_out;
      if (tx_ready) rdy_cnt++;
    end
    chk("idle_comma_bits", cap, {C, C});
    chk("tx_ready_slots", rdy_cnt, 2);
    for (int i = 0; i < 30; i++) begin
      if (rx_locked) break;
      step();
    end
    chk("lock_loopback", rx_locked, 1'b1);
    rx_q.delete();
    wait_valid(20, ev, ok);
    chk("idle_strobe_ok", ok, 1'b1);
    chk("idle_rx_data", ev.d, C);
    chk("idle_is_comma", ev.c, 1'b1);
    wait_valid(20, ev2, ok);
    chk("idle_strobe_gap", ev2.at - ev.at, 10);

    // Two back-to-back data symbols through loopback.
    rx_q.delete();
    send_sym(10'h2AA, "t2_send_a");
    send_sym(10'h155, "t2_send_b");
    tx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_valid(40, ev, ok);
      if (!ok || !ev.c) break;
    end
    chk("t2_first_ok", ok, 1'b1);
    chk("t2_first_data", ev.d, 10'h2AA);
    chk("t2_first_comma", ev.c, 1'b0);
    wait_valid(40, ev2, ok);
    chk("t2_second_data", ev2.d, 10'h155);
    chk("t2_second_comma", ev2.c, 1'b0);
    chk("t2_gap", ev2.at - ev.at, 10);

    // tx_valid held high with data changing every cycle.
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 35; i++) begin
      tx_data  = tbl[i % 8];
      tx_valid = 1'b1;
      if (tx_ready) exp_q.push_back(tbl[i % 8]);
      step();
    end
    tx_valid = 1'b0;
    chk("t3_accepted", exp_q.size() >= 3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      wait_valid(40, ev, ok);
      if (!ok || !ev.c) break;
    end
    for (int j = 0; j < exp_q.size(); j++) begin
      if (j > 0) wait_valid(40, ev, ok);
      chk($sformatf("t3_sym%0d", j), ev.d, exp_q[j]);
    end
    wait_valid(40, ev, ok);
    chk("t3_tail_comma", ev.c, 1'b1);

    // Lock on ser_in, then slip the phase by three bits.
    loopback = 1'b0;
    for (int s = 0; s < 16; s++) drive_sym(C);
    chk("t4_lock_serin", rx_locked, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      ser_in = 1'b0;
    end
    for (int s = 0; s < 4; s++) drive_sym(C);
    chk("t4_locked_after_3_miss", rx_locked, 1'b1);
    drive_sym(C);
    chk("t4_lost_after_4_miss", rx_locked, 1'b0);
    vc = valid_cnt;
    drive_sym(C);
    drive_sym(C);
    chk("t4_not_yet_relocked", rx_locked, 1'b0);
    chk("t4_no_strobe_unlocked", valid_cnt - vc, 0);
    drive_sym(C);
    chk("t4_relocked", rx_locked, 1'b1);
    rx_q.delete();
    drive_sym(C);
    wait_valid(5, ev, ok);
    chk("t4_relock_strobe", ok, 1'b1);
    chk("t4_relock_data", ev.d, C);

    // Reset asserted in the middle of a symbol while locked.
    for (int k = 0; k < 4; k++) begin
      step();
      ser_in = C[k];
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_reset_outs", {tx_ready, ser_out, rx_valid, rx_is_comma, rx_locked, rx_data}, 32'd0);
    step();
    step();
    rx_q.delete();
    ser_in  = 1'b0;
    reset_n = 1'b1;
    chk("t6_tx_ready_first_cycle", tx_ready, 1'b0);
    chk("t6_rx_hunt", rx_locked, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      cap10[k] = ser_out;
    end
    chk("t6_restart_comma", cap10, C);
    chk("t6_no_strobe", rx_q.size(), 0);

    // Inverted comma idles on ser_in.
    for (int s = 0; s < 4; s++) drive_sym(CN);
    rx_q.delete();
    drive_sym(CN);
    chk("t5_lock_inv_comma", rx_locked, 1'b1);
    wait_valid(5, ev, ok);
    chk("t5_strobe_ok", ok, 1'b1);
    chk("t5_rx_data", ev.d, CN);
    chk("t5_is_comma", ev.c, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
